// File: rtl/led_status_pkg.sv
// led_status_pkg: shared mode and channel-state encodings for the LED status controller
package led_status_pkg;

    typedef enum logic [1:0] {
        LED_MODE_OFF   = 2'd0,
        LED_MODE_ON    = 2'd1,
        LED_MODE_BLINK = 2'd2,
        LED_MODE_ACT   = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks plus a shared blink phase
//   clk_i   system clock
//   rst_i   asynchronous reset, active-high
//   tick_o  one-cycle registered tick
//   blink_o blink phase, toggles every BLINK_TICKS ticks
module led_tick_gen #(
    parameter int CLK_HZ      = 125_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic blink_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          tick_q, tick_d;
    logic          blink_q, blink_d;

    always_comb begin
        pcnt_d  = (pcnt_q == PMAX) ? '0 : pcnt_q + 1'b1;
        tick_d  = (pcnt_q == PMAX);
        bcnt_d  = tick_q ? ((bcnt_q == BMAX) ? '0 : bcnt_q + 1'b1) : bcnt_q;
        blink_d = blink_q ^ (tick_q && (bcnt_q == BMAX));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q  <= '0;
            bcnt_q  <= '0;
            tick_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            bcnt_q  <= bcnt_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
        end
    end

    assign tick_o  = tick_q;
    assign blink_o = blink_q;

endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED driver with off/on/blink/activity-stretch modes per channel
//   clk_i   system clock
//   rst_i   asynchronous reset, active-high
//   mode_i  per-channel mode, channel n at [2n+1:2n]
//   act_i   per-channel activity strobes
//   tick_o  one-cycle prescaler tick
//   blink_o shared blink phase
//   led_o   registered LED drive, inverted when ACTIVE_LOW
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CLK_HZ        = 125_000_000,
    parameter int TICK_HZ       = 1000,
    parameter int BLINK_TICKS   = 250,
    parameter int STRETCH_TICKS = 50,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0]   act_i,
    output logic                  tick_o,
    output logic                  blink_o,
    output logic [CHANNELS-1:0]   led_o
);

    localparam int CW = $clog2(STRETCH_TICKS + 1);
    localparam logic [CW-1:0] RELOAD = CW'(STRETCH_TICKS - 1);
    localparam logic [CHANNELS-1:0] POL = {CHANNELS{ACTIVE_LOW}};

    logic                tick;
    logic                blink;
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] led_q;

    led_tick_gen #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tick_o  (tick),
        .blink_o (blink)
    );

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        ch_state_e     state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          pend_q, pend_d;
        logic [1:0]    mode;
        logic          act;

        assign mode = mode_i[2*n +: 2];
        assign act  = act_i[n];

        // Activity arriving during ON or GAP is remembered so the burst restarts once the gap expires.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            if (mode != LED_MODE_ACT) begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (act) begin
                            state_d = ST_ON;
                            cnt_d   = RELOAD;
                            pend_d  = 1'b0;
                        end
                    end
                    ST_ON: begin
                        pend_d = pend_q | act;
                        if (tick) begin
                            state_d = (cnt_q == '0) ? ST_GAP : ST_ON;
                            cnt_d   = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
                        end
                    end
                    ST_GAP: begin
                        pend_d = pend_q | act;
                        if (tick) begin
                            if (cnt_q == '0) begin
                                state_d = (pend_q | act) ? ST_ON : ST_IDLE;
                                cnt_d   = RELOAD;
                                pend_d  = 1'b0;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
            end
        end

        assign raw[n] = (mode == LED_MODE_OFF)   ? 1'b0 :
                        (mode == LED_MODE_ON)    ? 1'b1 :
                        (mode == LED_MODE_BLINK) ? blink :
                        (state_q == ST_ON);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= POL;
        end else begin
            led_q <= raw ^ POL;
        end
    end

    assign tick_o  = tick;
    assign blink_o = blink;
    assign led_o   = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: scoreboard bench for led_status_ctrl, active-high and active-low instances side by side
module tb_led_status_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mode = 8'h55;
    logic [3:0] act = 4'h0;
    logic       tick, blink, tick_n, blink_n;
    logic [3:0] led, led_n;

    typedef struct {
        string      name;
        logic [5:0] mask;
        logic [5:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    led_status_ctrl #(
        .CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(100), .BLINK_TICKS(4), .STRETCH_TICKS(3), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .act_i(act), .tick_o(tick), .blink_o(blink), .led_o(led)
    );

    led_status_ctrl #(
        .CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(100), .BLINK_TICKS(4), .STRETCH_TICKS(3), .ACTIVE_LOW(1'b1)
    ) dut_n (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .act_i(act), .tick_o(tick_n), .blink_o(blink_n), .led_o(led_n)
    );

    // Expected word layout: {tick, blink, led[3:0]} for the active-high instance.
    task automatic push(input string nm, input logic [5:0] m, input logic [5:0] v, input int cnt);
        exp_t e;
        e.name = nm;
        e.mask = m;
        e.val  = v;
        repeat (cnt) sb.push_back(e);
    endtask

    task automatic push_l3(input string nm, input logic b, input int cnt);
        push(nm, 6'h08, {2'b00, b, 3'b000}, cnt);
    endtask

    task automatic drain(input int cnt);
        exp_t e;
        logic [5:0] o, on, vn;
        repeat (cnt) begin
            @(negedge clk);
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at t=%0t: got no expectation, required one per sampled cycle", $time);
            end else begin
                e  = sb.pop_front();
                o  = {tick, blink, led};
                on = {tick_n, blink_n, led_n};
                vn = {e.val[5:4], ~e.val[3:0]};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s t=%0t: got %b required %b (mask %b)", e.name, $time, o & e.mask, e.val & e.mask, e.mask);
                end
                n_chk++;
                if ((on & e.mask) !== (vn & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s_active_low t=%0t: got %b required %b (mask %b)", e.name, $time, on & e.mask, vn & e.mask, e.mask);
                end
            end
        end
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_tick: got no tick_o in 20 cycles, required one every 10");
        end
    endtask

    task automatic test_reset();
        logic [5:0] v;
        logic       t, b, l2;
        rst  = 1'b1;
        mode = 8'h55;
        act  = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        push("pre_reset_all_on", 6'h0F, 6'h0F, 2);
        drain(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (led !== 4'h0) begin n_fail++; $display("FAIL reset_led: got %h required 0", led); end
        n_chk++;
        if (led_n !== 4'hF) begin n_fail++; $display("FAIL reset_led_active_low: got %h required f", led_n); end
        n_chk++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b required 0", tick); end
        n_chk++;
        if (blink !== 1'b0) begin n_fail++; $display("FAIL reset_blink: got %b required 0", blink); end
        @(negedge clk);
        mode = 8'hE4;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            t  = (k % 10 == 0);
            b  = (k >= 41 && k <= 80) || k >= 121;
            l2 = (k >= 42 && k <= 81) || k >= 122;
            v  = {t, b, 1'b0, l2, 2'b10};
            push($sformatf("release_cycle_%0d", k), 6'h3F, v, 1);
        end
        drain(130);
    endtask

    task automatic test_mode_latency();
        mode = 8'h00;
        push("all_off", 6'h0F, 6'h00, 1);
        drain(1);
        mode = 8'h55;
        push("all_on", 6'h0F, 6'h0F, 1);
        drain(1);
        mode = 8'hE4;
        push("static_off_on_act", 6'h0B, 6'h02, 3);
        drain(3);
    endtask

    task automatic test_single_act();
        wait_tick();
        act = 4'b1000;
        push_l3("single_lat", 1'b0, 1);
        push_l3("single_on", 1'b1, 30);
        push_l3("single_off", 1'b0, 39);
        drain(1);
        act = 4'h0;
        drain(69);
    endtask

    task automatic test_short_first_tick();
        wait_tick();
        push_l3("late_pre", 1'b0, 9);
        drain(9);
        act = 4'b1000;
        push_l3("late_lat", 1'b0, 1);
        push_l3("late_on", 1'b1, 21);
        push_l3("late_off", 1'b0, 33);
        drain(1);
        act = 4'h0;
        drain(54);
    endtask

    task automatic test_continuous();
        wait_tick();
        act = 4'b1000;
        push_l3("cont_lat", 1'b0, 1);
        for (int c = 0; c < 5; c++) push_l3($sformatf("cont_phase_%0d", c), (c % 2 == 0), 30);
        drain(151);
        act  = 4'h0;
        mode = 8'h24;
        push_l3("cont_forced_off", 1'b0, 1);
        drain(1);
        mode = 8'hE4;
        push_l3("cont_back_idle", 1'b0, 40);
        drain(40);
    endtask

    task automatic test_pending();
        wait_tick();
        act = 4'b1000;
        push_l3("pend_lat", 1'b0, 1);
        push_l3("pend_on1", 1'b1, 30);
        push_l3("pend_gap1", 1'b0, 30);
        push_l3("pend_on2", 1'b1, 30);
        push_l3("pend_gap2", 1'b0, 30);
        push_l3("pend_coincident_on", 1'b1, 30);
        push_l3("pend_final_off", 1'b0, 34);
        drain(1);
        act = 4'h0;
        drain(39);
        act = 4'b1000;
        drain(1);
        act = 4'h0;
        drain(79);
        act = 4'b1000;
        drain(1);
        act = 4'h0;
        drain(64);
    endtask

    task automatic test_mode_change();
        wait_tick();
        act = 4'b1000;
        push_l3("mc_lat", 1'b0, 1);
        push_l3("mc_on", 1'b1, 9);
        push_l3("mc_off", 1'b0, 10);
        push_l3("mc_act_no_event", 1'b0, 40);
        drain(1);
        act = 4'h0;
        drain(9);
        mode = 8'h24;
        drain(5);
        act = 4'b1000;
        drain(1);
        act = 4'h0;
        drain(4);
        mode = 8'hE4;
        drain(40);
    endtask

    task automatic test_reset_mid_act();
        wait_tick();
        act = 4'b1000;
        push_l3("rma_lat", 1'b0, 1);
        push_l3("rma_on", 1'b1, 4);
        drain(5);
        rst = 1'b1;
        #1;
        n_chk++;
        if (led !== 4'h0) begin n_fail++; $display("FAIL reset_mid_act_led: got %h required 0", led); end
        n_chk++;
        if (led_n !== 4'hF) begin n_fail++; $display("FAIL reset_mid_act_led_active_low: got %h required f", led_n); end
        act = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        push_l3("rma_after_release", 1'b0, 40);
        drain(40);
    endtask

    initial begin
        test_reset();
        test_mode_latency();
        test_single_act();
        test_short_first_tick();
        test_continuous();
        test_pending();
        test_mode_change();
        test_reset_mid_act();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Parametrised multi-channel LED driver; successor to the single-LED divide-and-toggle blinker at board top level.
- Shared prescaler derives a slow tick from the system clock.
- Each channel independently selects off / on / blink / activity (pulse-stretched event) mode.
- Sits at the FPGA top and drives board LEDs from MAC/PHY status: link, rx_fifo_good_frame, tx activity, heartbeat.

Parameters:
- CHANNELS, 4, number of LED channels (1..16).
- CLK_HZ, 125_000_000, clk_i frequency in Hz.
- TICK_HZ, 1000, prescaler tick rate; DIV = CLK_HZ/TICK_HZ, must be >= 2.
- BLINK_TICKS, 250, ticks per blink half-period (>= 1).
- STRETCH_TICKS, 50, ticks of activity ON time and of the following forced OFF gap (>= 1).
- ACTIVE_LOW, 0, 1 = invert all led_o bits.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous reset, active-high
- mode_i  input  2*CHANNELS  per-channel mode, channel n at [2n+1:2n]: 0 OFF, 1 ON, 2 BLINK, 3 ACT
- act_i  input  CHANNELS  activity event strobes, any width >= 1 cycle, synchronous to clk_i
- tick_o  output  1  one-cycle prescaler tick
- blink_o  output  1  shared blink phase
- led_o  output  CHANNELS  LED drive, polarity per ACTIVE_LOW

Behaviour:
- Reset (async assert, sync release handled upstream): prescaler count 0, tick_o 0, blink count 0, blink_o 0, every channel FSM IDLE with pending 0, led_o = ACTIVE_LOW ? all ones : 0.
- Prescaler: pcnt counts 0..DIV-1 and wraps. tick_o = 1 for exactly the cycle after pcnt == DIV-1 (registered). Period is exactly DIV cycles.
- Blink: on tick_o, bcnt increments. At bcnt == BLINK_TICKS-1 it wraps to 0 and blink_o toggles. All BLINK channels share blink_o, so they are phase-aligned.
- Channel FSM states IDLE, ON, GAP, with a per-channel down-counter of width $clog2(STRETCH_TICKS+1):
  - IDLE: act_i[n] = 1 -> ON, cnt = STRETCH_TICKS-1, pending = 0.
  - ON: act_i[n] = 1 sets pending. On tick: cnt == 0 -> GAP with cnt = STRETCH_TICKS-1; otherwise cnt decrements.
  - GAP: act_i[n] = 1 sets pending. On tick with cnt == 0: pending | act_i[n] -> ON (reload, pending cleared); otherwise -> IDLE. Otherwise cnt decrements on tick.
  - ON lasts STRETCH_TICKS ticks; the first tick may arrive 1..DIV cycles after entry.
  - Continuous activity therefore flickers with period 2*STRETCH_TICKS ticks.
- act_i and tick in the same cycle: the state transition uses the tick and the pending set uses act_i; neither is lost.
- Mode values:
  - Mode != ACT: the channel FSM is forced to IDLE and pending cleared on the next edge.
  - Switching into ACT starts from IDLE.
- Output: raw[n] = 0 (OFF), 1 (ON), blink_o (BLINK), state == ON (ACT). led_o[n] <= raw[n] ^ ACTIVE_LOW, registered.
  - Latency: 1 cycle from a mode_i change.
  - Latency: 2 cycles from act_i to led_o assertion in IDLE (FSM register, then output register).
- Width rules: counters sized with $clog2. No arithmetic overflow: all counters wrap or reload explicitly.
- rst_i mid-sequence: immediate return to reset values; no pending state survives.

Decomposition:
- Shared package led_status_pkg:
  - mode encodings: LED_MODE_OFF=2'd0, LED_MODE_ON=2'd1, LED_MODE_BLINK=2'd2, LED_MODE_ACT=2'd3.
  - channel state encodings: ST_IDLE, ST_ON, ST_GAP.
- Sub-module led_tick_gen: prescaler plus blink counter; outputs tick_o and blink_o; parameters CLK_HZ, TICK_HZ, BLINK_TICKS.
- The channel FSM is a generate loop inside led_status_ctrl.

Test Plan (bench params CLK_HZ=1000, TICK_HZ=100 -> DIV=10, BLINK_TICKS=4, STRETCH_TICKS=3, CHANNELS=4):
- Reset check: assert rst_i mid-clock with ACTIVE_LOW=0 and then 1 -> led_o = 4'h0 / 4'hF immediately. tick_o first pulses 10 cycles after release, then every 10 cycles.
- Static modes: mode_i = {ACT,BLINK,ON,OFF} = 8'hE4 -> led_o[0] = 0, led_o[1] = 1 one cycle later. led_o[2] toggles every 40 cycles.
- Single activity: ch3 ACT, 1-cycle act_i pulse -> led_o[3] high 2 cycles later, for 3 ticks (21..30 cycles), then low. FSM returns to IDLE after 3 further ticks.
- Continuous activity: act_i[3] held 1 -> led_o[3] square wave, 30 cycles high / 30 cycles low, steady state.
- Pending capture: act pulse during GAP -> ON re-entered at GAP expiry. Act coincident with the final GAP tick also re-enters ON.
- Mode change mid-ON: switch ch3 ACT -> OFF during ON -> led_o[3] = 0 next cycle. Switch back to ACT with no act_i -> stays 0 (IDLE, pending cleared).
